// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small write FIFO and CTS flow control.
// Ports:
//   uart_clock  - system-rate clock, rising edge
//   reset       - asynchronous, active-high
//   data_in     - byte to queue, taken when write && ready
//   write       - write strobe, one byte per cycle
//   ready       - FIFO not full
//   cts         - peer clear-to-send (asynchronous, synchronised internally)
//   tx          - registered serial line, idle high
//   busy        - frame in progress or bytes queued
//   overflow    - sticky flag, a write arrived while full (cleared by reset)
module uart_tx #(
    parameter int CLK_FREQ      = 12000000,
    parameter int BAUD_RATE     = 115200,
    parameter int TICKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       uart_clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       ready,
    input  logic       cts,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic          cts_m, cts_s;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    shift_reg;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_idx;
    logic          push, pop, bit_end, tx_next;

    always_ff @(posedge uart_clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pop ? START : IDLE;
            START:   state_next = bit_end ? DATA : START;
            DATA:    state_next = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    state_next = bit_end ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready   = count < FULL;
        busy    = state != IDLE || count != '0;
        push    = write && ready;
        // cts is only honoured between frames, so a drop never cuts a frame short
        pop     = state == IDLE && count != '0 && cts_s;
        bit_end = tick_cnt == LAST_TICK;
        tx_next = tx;
        case (state)
            IDLE:    tx_next = !pop;
            START:   tx_next = bit_end ? shift_reg[0] : tx;
            DATA:    tx_next = bit_end ? (bit_idx == 3'd7 ? 1'b1 : shift_reg[0]) : tx;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clock or posedge reset)
        if (reset) begin
            tx        <= 1'b1;
            shift_reg <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            tx       <= tx_next;
            tick_cnt <= (state == IDLE || bit_end) ? '0 : tick_cnt + 1'b1;
            if (pop)
                shift_reg <= mem[rd_ptr];
            else if (bit_end && (state == START || (state == DATA && bit_idx != 3'd7)))
                shift_reg <= shift_reg >> 1;
            // leaving START zeroes the index; each DATA bit boundary advances it
            if (bit_end)
                bit_idx <= state == DATA ? bit_idx + 1'b1 : 3'd0;
        end

    always_ff @(posedge uart_clock or posedge reset)
        if (reset) begin
            cts_m    <= 1'b0;
            cts_s    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            cts_m  <= cts;
            cts_s  <= cts_m;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (write && !ready)
                overflow <= 1'b1;
        end

    always_ff @(posedge uart_clock)
        if (push) mem[wr_ptr] <= data_in;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor decodes frames and checks them against queued bytes.
module tb_uart_tx;
    localparam int T = 4;

    logic       uart_clock = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic       cts = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, tx, busy, overflow;

    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;
    int         n;
    logic [7:0] sb[$];
    int         starts[$];

    uart_tx #(.TICKS_PER_BIT(T), .FIFO_DEPTH(4)) dut (
        .uart_clock(uart_clock),
        .reset(reset),
        .data_in(data_in),
        .write(write),
        .ready(ready),
        .cts(cts),
        .tx(tx),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 uart_clock = ~uart_clock;
    always @(posedge uart_clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // line monitor: decodes each frame and compares it with the scoreboard head
    int         mpos = -1;
    logic [9:0] bits;
    bit         glitch;
    logic       prev_tx = 1'b1;
    int         k;
    logic [7:0] exp_b;

    always @(negedge uart_clock) begin
        if (reset) begin
            mpos = -1;
        end else begin
            if (mpos < 0 && prev_tx && !tx) begin
                mpos = 0;
                glitch = 0;
                starts.push_back(cyc);
            end
            if (mpos >= 0) begin
                k = mpos / T;
                if (mpos % T == 0) bits[k] = tx;
                else if (bits[k] !== tx) glitch = 1;
                if (mpos == 10*T - 1) begin
                    chk("start_bit", 32'(bits[0]), 32'd0);
                    chk("stop_bit", 32'(bits[9]), 32'd1);
                    chk("bit_width", 32'(glitch), 32'd0);
                    checks++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL frame_data: got 0x%0h expected no frame at cycle %0d", bits[8:1], cyc);
                    end else begin
                        exp_b = sb.pop_front();
                        if (bits[8:1] !== exp_b) begin
                            fails++;
                            $display("FAIL frame_data: got 0x%0h expected 0x%0h at cycle %0d", bits[8:1], exp_b, cyc);
                        end
                    end
                    mpos = -1;
                end else begin
                    mpos++;
                end
            end
        end
        prev_tx = tx;
    end

    task automatic tick(input int c);
        repeat (c) begin
            @(posedge uart_clock);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit acc);
        data_in = b;
        write = 1'b1;
        chk("ready_at_write", 32'(ready), 32'(acc));
        if (acc) sb.push_back(b);
        tick(1);
        write = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int c);
        c = 0;
        while (busy && c < bound) begin
            tick(1);
            c++;
        end
        chk("idle_within_bound", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcyc;
        tick(2);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        cts = 1'b1;
        tick(3);

        // single byte: latency, frame shape, busy fall
        starts.delete();
        wr(8'hA5, 1);
        wcyc = cyc;
        chk("tx_before_start", 32'(tx), 32'd1);
        chk("busy_after_write", 32'(busy), 32'd1);
        tick(1);
        chk("tx_start_fall", 32'(tx), 32'd0);
        wait_idle(100, n);
        chk("busy_latency", 32'(n + 1), 32'd41);
        chk("single_frames", 32'(starts.size()), 32'd1);
        if (starts.size() > 0) chk("start_latency", 32'(starts[0] - wcyc), 32'd1);
        tick(3);

        // back-to-back frames
        starts.delete();
        wr(8'h00, 1);
        wr(8'hFF, 1);
        wr(8'h55, 1);
        wait_idle(300, n);
        chk("b2b_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            chk("b2b_period_1", 32'(starts[1] - starts[0]), 32'd41);
            chk("b2b_period_2", 32'(starts[2] - starts[1]), 32'd41);
        end
        tick(3);

        // cts gating
        cts = 1'b0;
        tick(3);
        starts.delete();
        wr(8'h3C, 1);
        tick(5);
        chk("cts_hold_tx", 32'(tx), 32'd1);
        chk("cts_hold_busy", 32'(busy), 32'd1);
        cts = 1'b1;
        tick(1);
        chk("cts_edge1", 32'(tx), 32'd1);
        tick(1);
        chk("cts_edge2", 32'(tx), 32'd1);
        tick(1);
        chk("cts_edge3", 32'(tx), 32'd0);
        tick(12);
        cts = 1'b0;
        wait_idle(100, n);
        chk("cts_frames", 32'(starts.size()), 32'd1);
        chk("cts_sb_empty", 32'(sb.size()), 32'd0);
        tick(3);

        // FIFO full and overflow
        starts.delete();
        for (int i = 1; i <= 4; i++) wr(8'(i), 1);
        chk("full_ready", 32'(ready), 32'd0);
        chk("overflow_before", 32'(overflow), 32'd0);
        wr(8'h05, 0);
        chk("overflow_after", 32'(overflow), 32'd1);
        cts = 1'b1;
        wait_idle(300, n);
        chk("full_frames", 32'(starts.size()), 32'd4);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        chk("ready_after_drain", 32'(ready), 32'd1);
        tick(3);

        // reset mid-frame
        starts.delete();
        wr(8'h96, 1);
        wr(8'h42, 1);
        tick(17);
        chk("bit3_low", 32'(tx), 32'd0);
        #1 reset = 1'b1;
        #1 chk("async_reset_tx", 32'(tx), 32'd1);
        sb.delete();
        tick(2);
        reset = 1'b0;
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_overflow", 32'(overflow), 32'd0);
        chk("post_reset_ready", 32'(ready), 32'd1);
        chk("post_reset_tx", 32'(tx), 32'd1);
        starts.delete();
        tick(60);
        chk("flushed_no_frame", 32'(starts.size()), 32'd0);
        wr(8'h6B, 1);
        wait_idle(100, n);
        chk("post_reset_frames", 32'(starts.size()), 32'd1);
        tick(3);

        // pointer wrap streaming
        starts.delete();
        for (int i = 0; i < 10; i++) begin
            n = 0;
            while (!ready && n < 200) begin
                tick(1);
                n++;
            end
            wr(8'(8'h10 + i), 1);
        end
        wait_idle(600, n);
        chk("wrap_overflow", 32'(overflow), 32'd0);
        chk("wrap_frames", 32'(starts.size()), 32'd10);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
